// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake and
// loads the IF/ID register, redirecting on ID-stage branch/jump resolution.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic        jump,
   input  logic        if_flush,
   input  logic [31:0] branch_target,
   input  logic [31:0] jump_target,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid,
   output logic [31:0] fetch_count,
   output logic [1:0]  fsm_state
);

   // imem handshake: imem_req rises and stays high with imem_addr stable until
   // the cycle imem_ack is seen high; imem_rdata is taken in that same cycle.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_DROP = 2'd3
   } state_t;

   state_t      state, state_nx;
   logic [31:0] pc, pc_nx;
   logic [31:0] stale_addr, stale_nx;
   logic [31:0] hold_buf, buf_nx;
   logic [31:0] load_data;
   logic        load;
   logic        redirect;
   logic        flush;
   logic [31:0] target_al;
   logic [31:0] pc_plus4;

   assign redirect  = branch_taken | jump;
   assign flush     = if_flush | redirect;
   assign target_al = (jump ? jump_target : branch_target) & ~32'd3;
   assign pc_plus4  = pc + 32'd4;

   assign imem_req  = (state == S_WAIT) || (state == S_DROP);
   // DROP keeps presenting the abandoned request's address until it is acked.
   assign imem_addr = (state == S_DROP) ? stale_addr : pc;
   assign fsm_state = state;

   always_comb begin
      state_nx  = state;
      pc_nx     = pc;
      stale_nx  = stale_addr;
      buf_nx    = hold_buf;
      load      = 1'b0;
      load_data = hold_buf;
      case (state)
         S_IDLE: state_nx = S_WAIT;
         S_WAIT: begin
            if (imem_ack) begin
               if (redirect) begin
                  pc_nx = target_al;
               end else if (stall) begin
                  buf_nx   = imem_rdata;
                  state_nx = S_HOLD;
               end else begin
                  load      = 1'b1;
                  load_data = imem_rdata;
                  pc_nx     = pc_plus4;
               end
            end else if (redirect) begin
               pc_nx    = target_al;
               stale_nx = pc;
               state_nx = S_DROP;
            end
         end
         S_HOLD: begin
            if (redirect) begin
               pc_nx    = target_al;
               state_nx = S_WAIT;
            end else if (!stall) begin
               load      = 1'b1;
               load_data = hold_buf;
               pc_nx     = pc_plus4;
               state_nx  = S_WAIT;
            end
         end
         S_DROP: begin
            if (redirect) pc_nx = target_al;
            if (imem_ack) state_nx = S_WAIT;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         pc          <= RESET_PC;
         stale_addr  <= 32'd0;
         hold_buf    <= 32'd0;
         if_id_instr <= NOP_INSTR;
         if_id_pc4   <= 32'd0;
         if_id_valid <= 1'b0;
         fetch_count <= 32'd0;
      end else begin
         state      <= state_nx;
         pc         <= pc_nx;
         stale_addr <= stale_nx;
         hold_buf   <= buf_nx;
         // Flush beats both stall and a simultaneous load of IF/ID.
         if (flush) begin
            if_id_instr <= NOP_INSTR;
            if_id_pc4   <= 32'd0;
            if_id_valid <= 1'b0;
         end else if (load) begin
            if_id_instr <= load_data;
            if_id_pc4   <= pc_plus4;
            if_id_valid <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
         end
      end
   end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the ID-stage branch comparator.
- Owns the PC register and issues requests to instruction memory over a req/ack handshake.
- Loads the IF/ID pipeline register and consumes the ID-stage branch-taken, jump and flush signals to redirect fetch and squash the wrong-path instruction.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word written into IF/ID on flush/reset (sll $0,$0,0)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
imem_req  output  1  fetch request; held high until imem_ack
imem_addr  output  32  word-aligned fetch address; stable while imem_req high
imem_ack  input  1  one-cycle pulse; imem_rdata valid in the same cycle
imem_rdata  input  32  fetched instruction
stall  input  1  hazard unit: hold PC and IF/ID
branch_taken  input  1  ID-stage branch resolved taken
jump  input  1  ID-stage j instruction
if_flush  input  1  ID-stage flush request for IF/ID
branch_target  input  32  branch target address
jump_target  input  32  jump target address
if_id_instr  output  32  IF/ID instruction
if_id_pc4  output  32  IF/ID PC+4
if_id_valid  output  1  IF/ID holds a real instruction
fetch_count  output  32  count of instructions loaded into IF/ID

Behaviour:
- Reset (rst_n=0 at clk edge): pc=RESET_PC, state=IDLE, if_id_instr=NOP_INSTR, if_id_pc4=0, if_id_valid=0, fetch_count=0, hold buffer=0. imem_req=0 while in IDLE.
- Redirect: redirect=branch_taken|jump. Target is jump_target if jump=1, else branch_target; jump wins if both are set.
- Flush: IF/ID is flushed when if_flush|redirect. Flush loads if_id_instr=NOP_INSTR, if_id_pc4=0, if_id_valid=0. Flush overrides stall for IF/ID.
- imem_req=1 in WAIT and DROP, 0 otherwise. imem_addr=pc.
- IDLE: always goes to WAIT next cycle, so the first request is issued in the 2nd cycle after reset release.
- WAIT:
  - ack & redirect: discard rdata, pc<=target, stay WAIT.
  - ack & !redirect & !stall: IF/ID <= {rdata, pc+4, valid=1}, pc<=pc+4, fetch_count++, stay WAIT. The next request is issued the following cycle with the new address.
  - ack & stall & !redirect: rdata goes to the hold buffer, go HOLD. IF/ID is unchanged unless flushed.
  - !ack & redirect: pc<=target, go DROP, because the stale request is still outstanding.
  - !ack & !redirect: stay WAIT, all state held.
- HOLD:
  - redirect: discard buffer, pc<=target, go WAIT.
  - !stall: IF/ID <= {buffer, pc+4, 1}, pc<=pc+4, fetch_count++, go WAIT.
  - else: stay HOLD.
- DROP:
  - Address/req: imem_addr continues to present the stale address (a latched copy) until ack, so the address is stable while req is high.
  - ack: discard rdata, go WAIT. pc is the redirect target, or a newer target if one arrived this cycle.
  - Redirect while in DROP: updates pc (the new target), stays DROP.
- IF/ID hold: when stall=1 and no flush, all IF/ID outputs keep their value.
- if_flush without redirect: flushes IF/ID only; PC and FSM are unaffected.
- Arithmetic:
  - pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
  - fetch_count wraps modulo 2^32.
  - Targets are used as given; bits [1:0] are forced to 0 on load into pc.
- Reset mid-operation: an outstanding request is abandoned and imem_req drops the cycle after the reset edge. The memory must tolerate a dropped request.

Test Plan:
- Reset release, imem_ack one cycle after every req, rdata=addr^32'hA5A5_0000 -> addresses 0,4,8,C in order; if_id_pc4 4,8,C,10; if_id_valid=1 from the first ack; fetch_count=4 after the 4th ack.
- stall=1 in the ack cycle of addr 8 for 3 cycles -> IF/ID keeps the addr-4 instruction; imem_req=0 during HOLD; on release IF/ID gets the addr-8 word with pc4=C; the next request is addr C.
- branch_taken=1, branch_target=0x100 while the req for 0x10 waits (ack 3 cycles later) -> IF/ID flushed to NOP/valid=0; imem_addr stays 0x10 until ack; its data is discarded; the next request is 0x100; fetch_count is unchanged by the dropped word.
- jump=1 and branch_taken=1 together, jump_target=0x200, branch_target=0x300 -> the next fetch address is 0x200.
- if_flush=1 alone with stall=1 -> IF/ID becomes NOP/valid=0; PC sequence is unchanged.
- pc=32'hFFFF_FFFC, ack -> next imem_addr=0, if_id_pc4=0; assert rst_n=0 while a req is outstanding -> imem_req=0 and if_id_valid=0 the next cycle, and the first post-reset address is RESET_PC.
